// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit after last_grant, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional WAIT watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_din,
  output logic                       tx_start,
  output logic                       tx_stop,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   last_grant, last_nxt;
  logic [IDX_W-1:0]   gid_nxt;
  logic [DATA_W-1:0]  din_nxt;
  logic [NUM_REQ-1:0] ready_nxt;
  logic               start_nxt;
  logic               busy_nxt;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  state_t             done_state;

`ifdef UART_SCHED_TIMEOUT_EN
  logic stop_nxt, err_nxt;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (arb_found),
    .idx        (arb_idx)
  );

  // With no gap the frame end returns straight to arbitration.
  assign done_state = (GAP_CYCLES > 0) ? GAP : IDLE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_grant;
    gid_nxt   = grant_id;
    din_nxt   = tx_din;
    ready_nxt = '0;
    start_nxt = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    stop_nxt  = 1'b0;
    err_nxt   = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (arb_found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
              din_nxt      = req_data[DATA_W*i +: DATA_W];
              ready_nxt[i] = 1'b1;
            end
          end
          gid_nxt   = arb_idx;
          last_nxt  = arb_idx;
          start_nxt = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          cnt_nxt   = '0;
          state_nxt = done_state;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          stop_nxt  = 1'b1;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = done_state;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      tx_din     <= '0;
      req_ready  <= '0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_nxt;
      grant_id   <= gid_nxt;
      tx_din     <= din_nxt;
      req_ready  <= ready_nxt;
      tx_start   <= start_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_stop     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_stop     <= stop_nxt;
      timeout_err <= err_nxt;
    end
  end
`else
  assign tx_stop     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of arbitration vectors plus hand sequences.
module tb_uart_tx_scheduler;

  localparam int NR  = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_din;
  logic        tx_start;
  logic        tx_stop;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] valid;
    logic [1:0] gid;
    logic [7:0] din;
  } vec_t;

  vec_t tab[14];

  uart_tx_scheduler #(
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_din      (tx_din),
    .tx_start    (tx_start),
    .tx_stop     (tx_stop),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("start_seen", {31'b0, tx_start}, 1);
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] gid, input logic [7:0] din);
    chk({tag, "_ready"}, {28'b0, req_ready}, 32'(4'b0001 << gid));
    chk({tag, "_gid"}, {30'b0, grant_id}, {30'b0, gid});
    chk({tag, "_din"}, {24'b0, tx_din}, {24'b0, din});
    chk({tag, "_busy"}, {31'b0, busy}, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  int  n;
  logic saw_start, saw_idle;

  initial begin
    tab[0]  = '{4'b0001, 2'd0, 8'hA5};
    tab[1]  = '{4'b1111, 2'd1, 8'h3C};
    tab[2]  = '{4'b1111, 2'd2, 8'h5A};
    tab[3]  = '{4'b1111, 2'd3, 8'hC3};
    tab[4]  = '{4'b1111, 2'd0, 8'hA5};
    tab[5]  = '{4'b1111, 2'd1, 8'h3C};
    tab[6]  = '{4'b1111, 2'd2, 8'h5A};
    tab[7]  = '{4'b1111, 2'd3, 8'hC3};
    tab[8]  = '{4'b0100, 2'd2, 8'h5A};
    tab[9]  = '{4'b1010, 2'd3, 8'hC3};
    tab[10] = '{4'b1010, 2'd1, 8'h3C};
    tab[11] = '{4'b1001, 2'd3, 8'hC3};
    tab[12] = '{4'b0011, 2'd0, 8'hA5};
    tab[13] = '{4'b1000, 2'd3, 8'hC3};

    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
    tx_done   = 1'b0;
    repeat (3) step();
    chk("rst_ready", {28'b0, req_ready}, 0);
    chk("rst_start", {31'b0, tx_start}, 0);
    chk("rst_stop", {31'b0, tx_stop}, 0);
    chk("rst_din", {24'b0, tx_din}, 0);
    chk("rst_gid", {30'b0, grant_id}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_err", {31'b0, timeout_err}, 0);
    rst = 1'b1;
    step();

    // Table: each entry is one frame; the next mask is applied just before tx_done.
    req_valid = tab[0].valid;
    for (int i = 0; i < 14; i++) begin
      wait_start(n);
      if (i > 0) chk($sformatf("v%0d_latency", i), n + 1, GAP + 2);
      chk_grant($sformatf("v%0d", i), tab[i].gid, tab[i].din);
      step();
      chk($sformatf("v%0d_start_pulse", i), {31'b0, tx_start}, 0);
      chk($sformatf("v%0d_ready_pulse", i), {28'b0, req_ready}, 0);
      repeat (17) step();
      chk($sformatf("v%0d_din_hold", i), {24'b0, tx_din}, {24'b0, tab[i].din});
      chk($sformatf("v%0d_busy_wait", i), {31'b0, busy}, 1);
      req_valid = (i < 13) ? tab[i + 1].valid : 4'b0000;
      pulse_done();
    end
    repeat (GAP + 2) step();
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_start", {31'b0, tx_start}, 0);

    // tx_done during LAUNCH and during GAP must be ignored.
    req_valid = 4'b0010;
    wait_start(n);
    chk_grant("lg", 2'd1, 8'h3C);
    pulse_done();
    saw_start = 1'b0;
    saw_idle  = 1'b0;
    repeat (15) begin
      step();
      if (tx_start) saw_start = 1'b1;
      if (!busy) saw_idle = 1'b1;
    end
    chk("launch_done_restart", {31'b0, saw_start}, 0);
    chk("launch_done_idle", {31'b0, saw_idle}, 0);
    pulse_done();
    pulse_done();
    wait_start(n);
    chk("gap_done_latency", n + 2, GAP + 2);
    chk_grant("gd", 2'd1, 8'h3C);
    req_valid = 4'b0000;
    repeat (5) step();
    pulse_done();
    repeat (GAP + 2) step();
    chk("gd_idle_busy", {31'b0, busy}, 0);

`ifdef UART_SCHED_TIMEOUT_EN
    // No tx_done: watchdog aborts 50 clocks into WAIT and latches the error.
    req_valid = 4'b0001;
    wait_start(n);
    chk_grant("to", 2'd0, 8'hA5);
    n = 0;
    while (tx_stop !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("to_stop_seen", {31'b0, tx_stop}, 1);
    chk("to_stop_time", n, 51);
    chk("to_err_set", {31'b0, timeout_err}, 1);
    step();
    chk("to_stop_pulse", {31'b0, tx_stop}, 0);
    wait_start(n);
    chk_grant("to_next", 2'd0, 8'hA5);
    chk("to_err_sticky", {31'b0, timeout_err}, 1);
    req_valid = 4'b0000;
    repeat (5) step();
    pulse_done();
    repeat (GAP + 2) step();
    chk("to_err_after", {31'b0, timeout_err}, 1);
`else
    chk("no_to_stop", {31'b0, tx_stop}, 0);
    chk("no_to_err", {31'b0, timeout_err}, 0);
`endif

    // Reset mid-WAIT clears outputs at once and restores requester 0 priority.
    req_valid = 4'b1000;
    wait_start(n);
    chk_grant("rw", 2'd3, 8'hC3);
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("rw_ready", {28'b0, req_ready}, 0);
    chk("rw_start", {31'b0, tx_start}, 0);
    chk("rw_stop", {31'b0, tx_stop}, 0);
    chk("rw_din", {24'b0, tx_din}, 0);
    chk("rw_gid", {30'b0, grant_id}, 0);
    chk("rw_busy", {31'b0, busy}, 0);
    chk("rw_err", {31'b0, timeout_err}, 0);
    req_valid = 4'b1111;
    step();
    step();
    rst = 1'b1;
    wait_start(n);
    chk_grant("rw_after", 2'd0, 8'hA5);
    req_valid = 4'b0000;
    repeat (5) step();
    pulse_done();
    repeat (GAP + 2) step();
    chk("end_busy", {31'b0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
